// File: rtl/gamma_pkg.sv
// Shared encodings for the gamma mode controller: mode selects and debounce states.
package gamma_pkg;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RAW    = 2'd0,
    MODE_SQRT   = 2'd1,
    MODE_SQUARE = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    DEB_RELEASED   = 2'd0,
    DEB_PRESS_WAIT = 2'd1,
    DEB_HELD       = 2'd2,
    DEB_REL_WAIT   = 2'd3
  } deb_state_e;

  // Cycle raw -> sqrt -> square -> raw; anything else falls back to raw.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RAW:  next_mode = MODE_SQRT;
      MODE_SQRT: next_mode = MODE_SQUARE;
      default:   next_mode = MODE_RAW;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer and debouncer; emits one press pulse per debounced press.
module key_debounce
  import gamma_pkg::*;
#(
  parameter int unsigned DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_o
);

  // The entry sample counts as the first stable cycle, so the wait states count DEB_CNT-1 more.
  localparam int unsigned     CNT_W    = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 2);

  logic [1:0]       sync_q;
  logic             key_s;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  assign key_s   = sync_q[1];
  assign press_o = press_q;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_n};
  end

  // Debounce FSM with stability counter and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEB_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        DEB_RELEASED: begin
          cnt_q <= '0;
          if (!key_s) state_q <= DEB_PRESS_WAIT;
        end
        DEB_PRESS_WAIT: begin
          if (key_s) begin
            state_q <= DEB_RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DEB_HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DEB_HELD: begin
          cnt_q <= '0;
          if (key_s) state_q <= DEB_REL_WAIT;
        end
        default: begin
          if (!key_s) begin
            state_q <= DEB_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DEB_RELEASED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/gamma_mode_ctrl.sv
// Gamma path selector: button cycles a pending mode that is applied at frame start.
module gamma_mode_ctrl
  import gamma_pkg::*;
#(
  parameter int unsigned DEB_CNT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  input  logic [PIX_W-1:0] gamma_data_raw,
  input  logic [PIX_W-1:0] gamma_data_sqrt,
  input  logic [PIX_W-1:0] gamma_data_square,
  input  logic             gamma_de,
  input  logic             gamma_vs,
  output logic [PIX_W-1:0] out_data,
  output logic             out_de,
  output logic             out_vs,
  output logic [MODE_W-1:0] mode
);

  logic             press;
  logic             vs_q;
  mode_e            pending_q;
  mode_e            mode_q;
  logic [PIX_W-1:0] pix_sel_c;
  logic [PIX_W-1:0] out_data_q;
  logic             out_de_q;
  logic             out_vs_q;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_key_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .press_o(press)
  );

  // Presses accumulate into pending; mode picks up the pre-increment pending at each vs rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      pending_q <= MODE_RAW;
      mode_q    <= MODE_RAW;
    end else begin
      vs_q <= gamma_vs;
      if (gamma_vs && !vs_q) mode_q <= pending_q;
      if (press) pending_q <= next_mode(pending_q);
    end
  end

  // Pixel select by active mode; the unused encoding falls back to raw.
  always_comb begin
    pix_sel_c = gamma_data_raw;
    case (mode_q)
      MODE_SQRT:   pix_sel_c = gamma_data_sqrt;
      MODE_SQUARE: pix_sel_c = gamma_data_square;
      default:     pix_sel_c = gamma_data_raw;
    endcase
  end

  // One-cycle output stage; blanked pixels are forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_de_q   <= 1'b0;
      out_vs_q   <= 1'b0;
    end else begin
      out_data_q <= gamma_de ? pix_sel_c : '0;
      out_de_q   <= gamma_de;
      out_vs_q   <= gamma_vs;
    end
  end

  assign out_data = out_data_q;
  assign out_de   = out_de_q;
  assign out_vs   = out_vs_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_gamma_mode_ctrl.sv
// Directed bench for gamma_mode_ctrl with DEB_CNT = 4.
module tb_gamma_mode_ctrl;

  localparam int unsigned DEB = 4;
  localparam logic [15:0] RAW = 16'h1234;
  localparam logic [15:0] SQR = 16'hABCD;
  localparam logic [15:0] SQU = 16'h5555;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_n;
  logic [15:0] raw_d, sqrt_d, square_d;
  logic        de, vs;
  logic [15:0] out_data;
  logic        out_de, out_vs;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  gamma_mode_ctrl #(.DEB_CNT(DEB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .key_n            (key_n),
    .gamma_data_raw   (raw_d),
    .gamma_data_sqrt  (sqrt_d),
    .gamma_data_square(square_d),
    .gamma_de         (de),
    .gamma_vs         (vs),
    .out_data         (out_data),
    .out_de           (out_de),
    .out_vs           (out_vs),
    .mode             (mode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Clean press: low long enough to debounce, then released long enough to settle.
  task automatic press_key();
    key_n = 1'b0;
    repeat (8) tick();
    key_n = 1'b1;
    repeat (8) tick();
  endtask

  // One-cycle vs pulse; checks the new mode and the pixel selected in the next cycle.
  task automatic vs_frame(input string tag, input logic [1:0] exp_m, input logic [15:0] exp_d);
    vs = 1'b1;
    tick();
    chk({tag, "_mode"}, 16'(mode), 16'(exp_m));
    chk({tag, "_out_vs"}, 16'(out_vs), 16'h1);
    vs = 1'b0;
    tick();
    chk({tag, "_data"}, out_data, exp_d);
  endtask

  initial begin
    rst_n    = 1'b0;
    key_n    = 1'b1;
    raw_d    = RAW;
    sqrt_d   = SQR;
    square_d = SQU;
    de       = 1'b1;
    vs       = 1'b1;
    repeat (3) tick();
    chk("rst_mode", 16'(mode), 16'h0);
    chk("rst_data", out_data, 16'h0);
    chk("rst_de", 16'(out_de), 16'h0);
    chk("rst_vs", 16'(out_vs), 16'h0);

    // Raw passthrough after reset
    vs    = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("raw_data", out_data, RAW);
    chk("raw_mode", 16'(mode), 16'h0);
    chk("raw_de", 16'(out_de), 16'h1);

    // Press, mode held until vs rise
    press_key();
    chk("pre_edge_mode", 16'(mode), 16'h0);
    vs = 1'b1;
    tick();
    chk("edge_mode", 16'(mode), 16'h1);
    chk("edge_data_old", out_data, RAW);
    vs = 1'b0;
    tick();
    chk("sqrt_data", out_data, SQR);

    // Bouncing key: 2-cycle pulses never debounce
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0; repeat (2) tick();
      key_n = 1'b1; repeat (2) tick();
    end
    repeat (6) tick();
    vs_frame("bounce", 2'd1, SQR);

    // Two presses: 1 -> 2 -> 0
    press_key();
    press_key();
    vs_frame("two_press", 2'd0, RAW);

    // Three presses wrap back to raw
    repeat (3) press_key();
    vs_frame("three_press", 2'd0, RAW);

    // Four presses land on sqrt
    repeat (4) press_key();
    vs_frame("four_press", 2'd1, SQR);

    // Pending -> 2 without a frame edge
    press_key();
    chk("no_edge_mode", 16'(mode), 16'h1);

    // Press pulse lands in the same cycle as the vs rise
    key_n = 1'b0;
    repeat (6) tick();
    vs = 1'b1;
    tick();
    chk("coinc_mode", 16'(mode), 16'h2);
    vs = 1'b0;
    tick();
    chk("coinc_data", out_data, SQU);
    key_n = 1'b1;
    repeat (8) tick();
    vs_frame("after_coinc", 2'd0, RAW);

    // Blanking and vs delay
    de = 1'b0;
    tick();
    chk("blank_data", out_data, 16'h0);
    chk("blank_de", 16'(out_de), 16'h0);
    vs = 1'b1;
    #1;
    chk("vs_not_yet", 16'(out_vs), 16'h0);
    tick();
    chk("vs_delayed", 16'(out_vs), 16'h1);
    chk("blank_data_vs", out_data, 16'h0);
    vs = 1'b0;
    tick();
    chk("vs_fall", 16'(out_vs), 16'h0);
    de = 1'b1;
    tick();

    // Reset mid-press discards the partial press
    key_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    key_n = 1'b1;
    tick();
    chk("midrst_mode", 16'(mode), 16'h0);
    chk("midrst_data", out_data, 16'h0);
    rst_n = 1'b1;
    repeat (8) tick();
    vs_frame("midrst", 2'd0, RAW);

    // Key held through reset release: exactly one press however long it is held
    rst_n = 1'b0;
    key_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    key_n = 1'b1;
    repeat (8) tick();
    vs_frame("held_rst", 2'd1, SQR);

    // One more press reaches square
    press_key();
    vs_frame("square", 2'd2, SQU);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamma_mode_ctrl.md
GAMMA_MODE_CTRL -- requirements
Module: gamma_mode_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 1000000, SHALL set the number of clk cycles the key must stay stable to count as a press or release (20 ms at 50 MHz); minimum legal value is 2.
REQ-002 clk  input  1  single clock for all logic; rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 key_n  input  1  asynchronous push-button, low = pressed.
REQ-005 gamma_data_raw  input  16  RGB565 pixel, unmodified path.
REQ-006 gamma_data_sqrt  input  16  RGB565 pixel, brightened path; cycle-aligned with raw.
REQ-007 gamma_data_square  input  16  RGB565 pixel, darkened path; cycle-aligned with raw.
REQ-008 gamma_de  input  1  data enable, aligned with the three data inputs.
REQ-009 gamma_vs  input  1  vertical sync, active-high, aligned with the data inputs.
REQ-010 out_data  output  16  selected pixel.
REQ-011 out_de  output  1  delayed gamma_de.
REQ-012 out_vs  output  1  delayed gamma_vs.
REQ-013 mode  output  2  active mode: 0 = raw, 1 = sqrt, 2 = square.

Function
REQ-014 key_n SHALL pass through a 2-FF synchronizer before any use.
REQ-015 Debounce FSM states SHALL be RELEASED, PRESS_WAIT, HELD, REL_WAIT.
REQ-016 RELEASED -> PRESS_WAIT when the synced key is low.
REQ-017 PRESS_WAIT -> HELD after DEB_CNT consecutive low cycles; a high sample SHALL return the FSM to RELEASED.
REQ-018 HELD -> REL_WAIT when the synced key is high.
REQ-019 REL_WAIT -> RELEASED after DEB_CNT consecutive high cycles; a low sample SHALL return the FSM to HELD.
REQ-020 The debounce counter SHALL clear on every state change and SHALL never wrap.
REQ-021 The PRESS_WAIT -> HELD transition SHALL emit a one-cycle press pulse; a held key SHALL produce exactly one press.
REQ-022 A press pulse SHALL advance pending_mode 0 -> 1 -> 2 -> 0.
REQ-023 mode SHALL load pending_mode only in the cycle after a gamma_vs rising edge (gamma_vs = 1 with the previous sample = 0), so a switch never takes effect mid-frame.
REQ-024 If a press pulse and a vs rising edge coincide, mode SHALL take the pre-increment pending_mode; the increment SHALL apply at the next frame.
REQ-025 Multiple presses within one frame SHALL accumulate modulo 3; only the final pending value is applied.
REQ-026 Datapath latency SHALL be exactly 1 cycle: out_data, out_de and out_vs are registered from the same-cycle inputs.
REQ-027 out_data SHALL be the input selected by mode when gamma_de = 1, and 16'h0000 when gamma_de = 0.
REQ-028 An unreachable mode value of 3 SHALL select raw.

Reset
REQ-029 While rst_n = 0, all outputs SHALL be 0: mode = 0, out_data = 0, out_de = 0, out_vs = 0.
REQ-030 Reset values SHALL be: pending_mode = 0, debounce state RELEASED, counter 0, vs history 0, synchronizer flops 1 (released).
REQ-031 Reset asserted mid-debounce SHALL discard any partial press.
REQ-032 A key still held at reset release SHALL yield one press after DEB_CNT + 2 cycles.

Structure
REQ-033 Mode encodings (RAW/SQRT/SQUARE) and debounce state encodings SHALL live in the shared package gamma_pkg.
REQ-034 Debounce logic SHALL be one sub-module, key_debounce (clk, rst_n, key_n, DEB_CNT -> press pulse); the mux and mode logic SHALL stay in gamma_mode_ctrl.

Verification
All scenarios run with DEB_CNT = 4.
REQ-035 Reset release, gamma_de = 1, raw = 16'h1234 -> 1 cycle later out_data = 16'h1234, mode = 0.
REQ-036 key_n low for 8 cycles, then vs rising edge; sqrt = 16'hABCD -> mode = 1 starting the cycle after the edge; out_data = 16'hABCD the next cycle; mode unchanged before the edge.
REQ-037 key_n toggling with 2-cycle pulses for 20 cycles -> no press, pending_mode unchanged.
REQ-038 Three clean presses within one frame -> mode = 0 after vs; four presses -> mode = 1.
REQ-039 Press pulse coincident with vs rising edge -> mode keeps the old pending value this frame and takes the new value at the following vs edge.
REQ-040 gamma_de = 0 with nonzero inputs -> out_data = 0; out_vs follows gamma_vs with a 1-cycle delay; rst_n pulsed mid-press -> no mode change.
